// File: rtl/seq_det_ctrl_pkg.sv
// Shared constants for the programmable sequence detector: FSM encodings,
// power-on configuration and a config-length validity helper.
package seq_det_ctrl_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int DEF_PATTERN = 'b1011;
    localparam int DEF_LEN     = 4;
    localparam bit DEF_OVERLAP = 1'b1;

    // A pattern length is usable only when it names at least one bit and fits the history.
    function automatic logic len_valid(input int len, input int maxlen);
        return (len >= 1) && (len <= maxlen);
    endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Command, config, serial data and status bundle for seq_det_ctrl.
// The master side drives commands and data; the slave side is the detector.
interface seq_det_ctrl_if #(
    parameter int MAXLEN = 8,
    parameter int LENW   = 4,
    parameter int CNTW   = 8
);
    logic              cfg_load;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [LENW-1:0]   cfg_len;
    logic              cfg_overlap;
    logic              start;
    logic              stop;
    logic              PI;
    logic              PI_valid;
    logic              PO;
    logic              busy;
    logic [CNTW-1:0]   match_count;
    logic              cfg_err;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, start, stop, PI, PI_valid,
        input  PO, busy, match_count, cfg_err
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, start, stop, PI, PI_valid,
        output PO, busy, match_count, cfg_err
    );
endinterface

// File: rtl/seq_match_core.sv
// History shift register, saturating fill counter and masked pattern comparator.
// match_next reflects the history as it will be after the current sample.
module seq_match_core #(
    parameter int MAXLEN = 8,
    parameter int LENW   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              sample,
    input  logic              pi,
    input  logic [MAXLEN-1:0] pattern,
    input  logic [LENW-1:0]   len,
    input  logic              overlap,
    output logic              match_next
);

    logic [MAXLEN-1:0] history;
    logic [MAXLEN-1:0] hist_next;
    logic [MAXLEN-1:0] mask;
    logic [LENW-1:0]   fill;
    logic [LENW-1:0]   fill_next;

    // Only the low len bits take part in the compare; a full-width shift yields an all-ones mask.
    always_comb begin
        hist_next  = {history[MAXLEN-2:0], pi};
        fill_next  = (fill >= LENW'(MAXLEN)) ? fill : fill + LENW'(1);
        mask       = ~({MAXLEN{1'b1}} << len);
        match_next = sample && (fill_next >= len) && (((hist_next ^ pattern) & mask) == '0);
    end

    // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            history <= '0;
            fill    <= '0;
        end else if (clear) begin
            history <= '0;
            fill    <= '0;
        end else if (sample) begin
            history <= hist_next;
            fill    <= (match_next && !overlap) ? '0 : fill_next;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence-detector controller: run/idle sequencing,
// configuration registers, registered match pulse and saturating match counter.
module seq_det_ctrl
    import seq_det_ctrl_pkg::*;
#(
    parameter int MAXLEN = 8,
    parameter int LENW   = 4,
    parameter int CNTW   = 8
) (
    input logic         clk,
    input logic         reset,
    seq_det_ctrl_if.slave bus
);

    logic [0:0]        state;
    logic [MAXLEN-1:0] pattern;
    logic [LENW-1:0]   len;
    logic              overlap;
    logic              po;
    logic [CNTW-1:0]   count;
    logic              err;
    logic              start_run;
    logic              sample;
    logic              load_ok;
    logic              match_next;

    // A valid bit arriving together with stop is dropped.
    always_comb begin
        start_run = (state == ST_IDLE) && bus.start;
        sample    = (state == ST_RUN) && bus.PI_valid && !bus.stop;
        load_ok   = len_valid(int'(bus.cfg_len), MAXLEN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (state == ST_IDLE) begin
            if (bus.start) state <= ST_RUN;
        end else begin
            if (bus.stop) state <= ST_IDLE;
        end
    end

    // Loads are honoured only while idle; a load alongside start takes effect for that run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern <= MAXLEN'(DEF_PATTERN);
            len     <= LENW'(DEF_LEN);
            overlap <= DEF_OVERLAP;
            err     <= 1'b0;
        end else if (bus.cfg_load) begin
            if ((state == ST_IDLE) && load_ok) begin
                pattern <= bus.cfg_pattern;
                len     <= bus.cfg_len;
                overlap <= bus.cfg_overlap;
                err     <= 1'b0;
            end else begin
                err     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            po    <= 1'b0;
            count <= '0;
        end else begin
            po <= match_next;
            if (start_run) begin
                count <= '0;
            end else if (match_next && (count != {CNTW{1'b1}})) begin
                count <= count + CNTW'(1);
            end
        end
    end

    seq_match_core #(
        .MAXLEN (MAXLEN),
        .LENW   (LENW)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_run),
        .sample     (sample),
        .pi         (bus.PI),
        .pattern    (pattern),
        .len        (len),
        .overlap    (overlap),
        .match_next (match_next)
    );

    assign bus.PO          = po;
    assign bus.busy        = (state == ST_RUN);
    assign bus.match_count = count;
    assign bus.cfg_err     = err;

endmodule
